// File: rtl/nv_seq_scheduler.sv
// Table-driven sequencer for the shared NV pulse datapath: each step loads a pattern
// into the serializer, optionally gates on APD clicks, then advances, retries or fails.
module nv_seq_scheduler #(
    parameter int NUM_STEPS = 4,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 8,
    parameter int GATE_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              cfg_gate,
    input  logic [1:0]        last_step,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic [3:0]        max_retry,
    output logic [DATA_W-1:0] ser_data,
    output logic              ser_reset,
    output logic              ser_start,
    input  logic              ser_done,
    output logic              cnt_reset,
    input  logic [CNT_W-1:0]  click_count,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [1:0]        cur_step,
    output logic [3:0]        retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GATE,
        S_DONE,
        S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         step_q, step_d;
    logic [3:0]         retry_q, retry_d;
    logic [GATE_W-1:0]  timer_q, timer_d;

    logic [DATA_W-1:0]  pattern_q [NUM_STEPS];
    logic [CNT_W-1:0]   thresh_q  [NUM_STEPS];
    logic [NUM_STEPS-1:0] gate_q;

    logic               idle_like;
    logic [GATE_W-1:0]  gate_last;
    logic [DATA_W-1:0]  cur_pattern;
    logic [CNT_W-1:0]   cur_thresh;
    logic               cur_gated;
    logic               pass_go;
    logic               timeout_go;

    assign idle_like   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL);
    // A zero window length still gives the counter one cycle to be sampled.
    assign gate_last   = (gate_cycles == '0) ? '0 : gate_cycles - GATE_W'(1);
    assign cur_pattern = pattern_q[step_q];
    assign cur_thresh  = thresh_q[step_q];
    assign cur_gated   = gate_q[step_q];

    generate
        for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_table
            always_ff @(posedge clk) begin
                if (reset) begin
                    pattern_q[gi] <= '0;
                    thresh_q[gi]  <= '0;
                    gate_q[gi]    <= 1'b0;
                end else if (cfg_we && idle_like && (cfg_addr == 2'(gi))) begin
                    pattern_q[gi] <= cfg_pattern;
                    thresh_q[gi]  <= cfg_thresh;
                    gate_q[gi]    <= cfg_gate;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            retry_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            retry_q <= retry_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        retry_d    = retry_q;
        timer_d    = timer_q;
        pass_go    = 1'b0;
        timeout_go = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_d = S_LOAD;
                    step_d  = '0;
                    retry_d = '0;
                end
            end
            S_LOAD: state_d = S_SEND;
            S_SEND: begin
                if (ser_done) begin
                    if (cur_gated) begin
                        state_d = S_GATE;
                        timer_d = '0;
                    end else begin
                        pass_go = 1'b1;
                    end
                end
            end
            S_GATE: begin
                timer_d = timer_q + GATE_W'(1);
                // Reaching the threshold on the final window cycle still counts as a pass.
                if (click_count >= cur_thresh) begin
                    pass_go = 1'b1;
                end else if (timer_q == gate_last) begin
                    timeout_go = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pass_go) begin
            if (step_q == last_step) begin
                state_d = S_DONE;
            end else begin
                state_d = S_LOAD;
                step_d  = step_q + 2'd1;
                retry_d = '0;
            end
        end else if (timeout_go) begin
            if (retry_q == max_retry) begin
                state_d = S_FAIL;
            end else begin
                state_d = S_LOAD;
                retry_d = retry_q + 4'd1;
            end
        end

        if (abort) begin
            state_d = S_IDLE;
            step_d  = '0;
            retry_d = '0;
            timer_d = '0;
        end
    end

    always_comb begin
        ser_data  = '0;
        ser_reset = 1'b1;
        ser_start = 1'b0;
        cnt_reset = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        fail      = 1'b0;
        case (state_q)
            S_LOAD: begin
                ser_data  = cur_pattern;
                ser_start = 1'b1;
                busy      = 1'b1;
            end
            S_SEND: begin
                ser_data  = cur_pattern;
                ser_start = 1'b1;
                ser_reset = 1'b0;
                busy      = 1'b1;
            end
            S_GATE: begin
                ser_data  = cur_pattern;
                ser_start = 1'b1;
                ser_reset = 1'b0;
                cnt_reset = 1'b0;
                busy      = 1'b1;
            end
            S_DONE:  done = 1'b1;
            S_FAIL:  fail = 1'b1;
            default: ;
        endcase
    end

    assign cur_step  = step_q;
    assign retry_cnt = retry_q;

endmodule

// File: doc/nv_seq_scheduler.md
Name: nv_seq_scheduler

Overview:
- Sequences the shared NV pulse datapath (serializer, APD click counter, gate timing) through a programmable table of up to NUM_STEPS pattern steps.
- Each step shifts an 8-bit pattern out through the serializer, then optionally gates on APD clicks.
- After an optional gate, the step advances, retries, or aborts with failure.
- Sits between the host/config logic and the serializer and counter instances, replacing hard-wired init/transmit/terminate sequencing.

Parameters:
- NUM_STEPS, 4, number of table entries (power of two, max 4).
- DATA_W, 8, pattern width driven to the serializer.
- CNT_W, 8, click count / threshold width.
- GATE_W, 16, width of the gate-window timer.

Ports:
- clk  in  1  system clock (divided clock domain).
- reset  in  1  synchronous, active-high.
- start  in  1  begin sequence at step 0; sampled in IDLE/DONE/FAIL only.
- abort  in  1  abandon sequence, return to IDLE.
- cfg_we  in  1  table write strobe; ignored while busy.
- cfg_addr  in  2  table entry index.
- cfg_pattern  in  DATA_W  pattern for the entry.
- cfg_thresh  in  CNT_W  click threshold for the entry.
- cfg_gate  in  1  1 = click-gated step; 0 = advance on serializer done.
- last_step  in  2  index of final step (steps 0..last_step run).
- gate_cycles  in  GATE_W  gate window length in clk cycles; 0 is treated as 1.
- max_retry  in  4  retries allowed per step before FAIL.
- ser_data  out  DATA_W  pattern to serializer.
- ser_reset  out  1  serializer reset.
- ser_start  out  1  serializer start/enable level.
- ser_done  in  1  serializer transmit-complete.
- cnt_reset  out  1  click counter reset.
- click_count  in  CNT_W  click counter value.
- busy  out  1  sequence in progress.
- done  out  1  sticky success.
- fail  out  1  sticky retry-exhaustion failure.
- cur_step  out  2  step currently executing.
- retry_cnt  out  4  retries consumed on cur_step.

Behaviour:
- States: IDLE, LOAD, SEND, GATE, DONE, FAIL.
- Reset:
  - State goes to IDLE.
  - Outputs: ser_reset=1, cnt_reset=1, ser_start=0, ser_data=0, busy=0, done=0, fail=0, cur_step=0, retry_cnt=0.
  - All table entries cleared to pattern=0, thresh=0, gate=0.
- Table writes:
  - cfg_we in IDLE/DONE/FAIL writes entry cfg_addr on that edge.
  - Dropped while busy.
  - Entries above last_step are never used.
- Start:
  - start in IDLE/DONE/FAIL: next cycle is LOAD with cur_step=0, retry_cnt=0, done=0, fail=0, busy=1.
  - start while busy is ignored.
- LOAD (exactly 1 cycle):
  - ser_reset=1, cnt_reset=1, ser_start=1, ser_data=pattern[cur_step].
  - Go to SEND.
- SEND:
  - ser_reset=0. Hold ser_data and ser_start.
  - Wait for ser_done=1.
  - On ser_done, if gate[cur_step]=1: go to GATE with cnt_reset=0 and gate timer=0.
  - On ser_done, if gate[cur_step]=0: take the pass path.
- GATE:
  - Gate timer increments every cycle.
  - Pass when click_count >= thresh[cur_step] (unsigned).
  - Timeout when timer == max(gate_cycles,1)-1 and not passing.
  - Pass has priority over timeout on the same cycle.
- Pass path:
  - If cur_step == last_step: go to DONE.
  - Otherwise cur_step+1, retry_cnt=0, go to LOAD.
- Timeout path:
  - If retry_cnt == max_retry: go to FAIL.
  - Otherwise retry_cnt+1, go to LOAD for the same step (counter is re-cleared there).
- DONE/FAIL:
  - busy=0; done=1 or fail=1 respectively (sticky).
  - ser_start=0, ser_reset=1, cnt_reset=1.
  - cur_step and retry_cnt hold their final values.
- abort:
  - Honoured in any state; highest priority below reset.
  - Next cycle: IDLE, busy=0, done=0, fail=0, ser_start=0, ser_reset=1, cnt_reset=1.
  - Table contents retained.
  - start and abort in the same cycle: abort wins.
- Configuration sampling: last_step, gate_cycles and max_retry are read live. The host must hold them stable while busy; behaviour under change is undefined.
- Latency:
  - start to first ser_reset deassert: 2 cycles.
  - ser_done to GATE entry: 1 cycle.
  - Pass/timeout decision to next LOAD: 1 cycle.
- Widths: the gate timer is GATE_W bits and never wraps, because it is compared against gate_cycles-1.

Test Plan:
- 3 ungated steps, patterns D7/A6/29, last_step=2, ser_done pulsed 9 cycles after each LOAD → ser_data sequence D7,A6,29; done=1, fail=0, cur_step=2.
- Step 0 gated, thresh=0x40, gate_cycles=100, click_count ramps to 0x40 at cycle 50 → advance to step 1 with retry_cnt=0 and no FAIL.
- Gated step, thresh=0x40, clicks held at 0x10, max_retry=2, gate_cycles=20 → exactly 3 LOAD pulses on step 0, then fail=1, retry_cnt=2.
- Click threshold reached on the same cycle as timeout → pass taken; retry_cnt unchanged.
- abort asserted mid-SEND on step 1 → next cycle busy=0, ser_start=0, ser_reset=1, cnt_reset=1; a following start reruns from step 0 with table intact.
- cfg_we during busy, and gate_cycles=0 → table write dropped (read back via the next run's ser_data); gate window is 1 cycle.
